// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bundle: decoded ID fields and MEM branch in; stall, flushes,
// forwarding selects and performance counters out.
interface pipeline_hazard_unit_if #(
   parameter int REG_W = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_regwrite;
   logic             id_memread;
   logic             branch_taken;
   logic             stall;
   logic             flush_ifid;
   logic             flush_idex;
   logic             flush_exmem;
   logic [DEPTH-2:0] fwd_a;
   logic [DEPTH-2:0] fwd_b;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] retire_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output id_rd, id_regwrite, id_memread, branch_taken,
      input  stall, flush_ifid, flush_idex, flush_exmem,
      input  fwd_a, fwd_b, stall_count, flush_count, retire_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  id_rd, id_regwrite, id_memread, branch_taken,
      output stall, flush_ifid, flush_idex, flush_exmem,
      output fwd_a, fwd_b, stall_count, flush_count, retire_count
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard/interlock controller: shadow pipeline of in-flight regs, load-use or
// full interlock stall, MEM-resolved branch flush, EX forwarding, perf counters.
// Ports: clk, reset (sync, active-high), hz (slave side of the bundle).
module pipeline_hazard_unit #(
   parameter int REG_W    = 5,
   parameter int DEPTH    = 3,
   parameter int ZERO_REG = 31,
   parameter int FWD_EN   = 1,
   parameter int CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_unit_if.slave hz
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             rs1_used;
      logic             rs2_used;
      logic             regwrite;
      logic             memread;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   entry_t           id_ent;
   logic             hazard;
   logic             stall;
   logic             flush;
   logic [DEPTH-2:0] fwd_a;
   logic [DEPTH-2:0] fwd_b;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             unused_bits;

   function automatic logic hit(input logic             used,
                                input logic [REG_W-1:0] src,
                                input entry_t           e);
      return used && (src != ZR) && e.valid && e.regwrite && (e.rd == src);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             en);
      return (en && (c != '1)) ? c + CNT_W'(1) : c;
   endfunction

   always_comb begin
      id_ent          = '0;
      id_ent.valid    = hz.id_valid;
      id_ent.rd       = hz.id_rd;
      id_ent.rs1      = hz.id_rs1;
      id_ent.rs2      = hz.id_rs2;
      id_ent.rs1_used = hz.id_rs1_used;
      id_ent.rs2_used = hz.id_rs2_used;
      id_ent.regwrite = hz.id_regwrite;
      id_ent.memread  = hz.id_memread;
   end

   // With forwarding only a load in EX needs a bubble; without it every
   // producer still ahead of WB does (WB is covered by write-first regfile).
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN != 0) begin
         hazard = ent_q[0].memread &&
                  (hit(id_ent.rs1_used, id_ent.rs1, ent_q[0]) ||
                   hit(id_ent.rs2_used, id_ent.rs2, ent_q[0]));
      end else begin
         for (int j = 0; j < DEPTH-1; j++) begin
            hazard = hazard |
                     hit(id_ent.rs1_used, id_ent.rs1, ent_q[j]) |
                     hit(id_ent.rs2_used, id_ent.rs2, ent_q[j]);
         end
      end
   end

   assign stall = !reset && !hz.branch_taken && hz.id_valid && hazard;
   assign flush = !reset && hz.branch_taken;

   // Scan oldest to youngest so the youngest producer overwrites the select.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      if ((FWD_EN != 0) && !reset && ent_q[0].valid) begin
         for (int k = DEPTH-1; k >= 1; k--) begin
            if (hit(ent_q[0].rs1_used, ent_q[0].rs1, ent_q[k])) begin
               fwd_a        = '0;
               fwd_a[k-1]   = 1'b1;
            end
            if (hit(ent_q[0].rs2_used, ent_q[0].rs2, ent_q[k])) begin
               fwd_b        = '0;
               fwd_b[k-1]   = 1'b1;
            end
         end
      end
   end

   // A taken branch in MEM squashes both the ID and the EX instruction.
   always_comb begin
      ent_d[0] = (stall || hz.branch_taken || !hz.id_valid) ? '0 : id_ent;
      for (int i = 1; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i-1];
      end
      if (hz.branch_taken) begin
         ent_d[1] = '0;
      end
      stall_cnt_d  = sat_inc(stall_cnt_q, stall);
      flush_cnt_d  = sat_inc(flush_cnt_q, hz.branch_taken);
      retire_cnt_d = sat_inc(retire_cnt_q, ent_q[DEPTH-1].valid);
   end

   always_comb begin
      unused_bits = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         unused_bits = unused_bits ^ (^ent_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign hz.stall        = stall;
   assign hz.flush_ifid   = flush;
   assign hz.flush_idex   = flush;
   assign hz.flush_exmem  = flush;
   assign hz.fwd_a        = fwd_a;
   assign hz.fwd_b        = fwd_b;
   assign hz.stall_count  = stall_cnt_q;
   assign hz.flush_count  = flush_cnt_q;
   assign hz.retire_count = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: forwarding instance driven from a vector
// table, interlock-only instance (2-bit counters) driven by a hand sequence.
module tb_pipeline_hazard_unit;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit_if #(.REG_W(5), .DEPTH(3), .CNT_W(32)) if0 ();
   pipeline_hazard_unit_if #(.REG_W(5), .DEPTH(3), .CNT_W(2))  if1 ();

   pipeline_hazard_unit #(
      .REG_W(5), .DEPTH(3), .ZERO_REG(31), .FWD_EN(1), .CNT_W(32)
   ) u_fwd (
      .clk(clk), .reset(rst0), .hz(if0.slave)
   );

   pipeline_hazard_unit #(
      .REG_W(5), .DEPTH(3), .ZERO_REG(31), .FWD_EN(0), .CNT_W(2)
   ) u_ilk (
      .clk(clk), .reset(rst1), .hz(if1.slave)
   );

   typedef struct {
      string      nm;
      bit         rst;
      bit         v;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      bit         u1;
      bit         u2;
      bit         rw;
      bit         mr;
      bit         br;
      bit         x_stall;
      bit         x_flush;
      logic [1:0] x_fa;
      logic [1:0] x_fb;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(string nm, bit rst, bit v, int rd, int rs1,
                               int rs2, bit u1, bit u2, bit rw, bit mr,
                               bit br, bit xs, bit xf, int xa, int xb);
      vec_t t;
      t.nm = nm; t.rst = rst; t.v = v;
      t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
      t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr; t.br = br;
      t.x_stall = xs; t.x_flush = xf;
      t.x_fa = 2'(xa); t.x_fb = 2'(xb);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive1(input bit rst, input bit v, input int rd,
                         input int rs1, input int rs2, input bit br);
      rst1             = rst;
      if1.id_valid     = v;
      if1.id_rd        = 5'(rd);
      if1.id_rs1       = 5'(rs1);
      if1.id_rs2       = 5'(rs2);
      if1.id_rs1_used  = 1'b1;
      if1.id_rs2_used  = 1'b1;
      if1.id_regwrite  = 1'b1;
      if1.id_memread   = 1'b0;
      if1.branch_taken = br;
   endtask

   initial begin
      // cycle-ordered table for the forwarding instance
      //            name        rst v  rd rs1 rs2 u1 u2 rw mr br  st fl fa fb
      tbl[0]  = mk("rst_force", 1, 1, 2,  9,  0, 1, 0, 1, 1, 1,  0, 0, 0, 0);
      tbl[1]  = mk("ldur_x2",   0, 1, 2,  9,  0, 1, 0, 1, 1, 0,  0, 0, 0, 0);
      tbl[2]  = mk("lu_stall",  0, 1, 3,  2,  4, 1, 1, 1, 0, 0,  1, 0, 0, 0);
      tbl[3]  = mk("lu_once",   0, 1, 3,  2,  4, 1, 1, 1, 0, 0,  0, 0, 0, 0);
      tbl[4]  = mk("lu_fwd_wb", 0, 1, 1,  0,  0, 1, 1, 1, 0, 0,  0, 0, 2, 0);
      tbl[5]  = mk("sub_id",    0, 1, 5,  1,  1, 1, 1, 1, 0, 0,  0, 0, 0, 0);
      tbl[6]  = mk("sub_ex",    0, 1, 1,  8,  8, 1, 1, 1, 0, 0,  0, 0, 1, 1);
      tbl[7]  = mk("add_x1_2",  0, 1, 1,  8,  8, 1, 1, 1, 0, 0,  0, 0, 0, 0);
      tbl[8]  = mk("add_x6_id", 0, 1, 6,  1,  7, 1, 1, 1, 0, 0,  0, 0, 0, 0);
      tbl[9]  = mk("youngest",  0, 1, 31, 9,  0, 1, 0, 1, 1, 0,  0, 0, 1, 0);
      tbl[10] = mk("xzr_nostl", 0, 1, 10, 31, 31, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      tbl[11] = mk("xzr_nofwd", 0, 1, 4,  10, 0, 1, 0, 1, 1, 0,  0, 0, 0, 0);
      tbl[12] = mk("br_lu",     0, 1, 11, 4,  4, 1, 1, 1, 0, 1,  0, 1, 1, 0);
      tbl[13] = mk("br_sq_ex",  0, 1, 12, 4,  4, 1, 1, 1, 0, 0,  0, 0, 0, 0);
      tbl[14] = mk("br_sq_mem", 0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

      rst1 = 1'b1;
      drive1(1'b1, 1'b0, 0, 0, 0, 1'b0);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rst0             = tbl[i].rst;
         if0.id_valid     = tbl[i].v;
         if0.id_rd        = tbl[i].rd;
         if0.id_rs1       = tbl[i].rs1;
         if0.id_rs2       = tbl[i].rs2;
         if0.id_rs1_used  = tbl[i].u1;
         if0.id_rs2_used  = tbl[i].u2;
         if0.id_regwrite  = tbl[i].rw;
         if0.id_memread   = tbl[i].mr;
         if0.branch_taken = tbl[i].br;
         #1;
         chk({tbl[i].nm, ".stall"}, 32'(if0.stall), 32'(tbl[i].x_stall));
         chk({tbl[i].nm, ".flush"},
             32'({if0.flush_ifid, if0.flush_idex, if0.flush_exmem}),
             32'({3{tbl[i].x_flush}}));
         chk({tbl[i].nm, ".fwd_a"}, 32'(if0.fwd_a), 32'(tbl[i].x_fa));
         chk({tbl[i].nm, ".fwd_b"}, 32'(if0.fwd_b), 32'(tbl[i].x_fb));
         if (i == 1) begin
            chk("rst_cnt.stall", if0.stall_count, 32'd0);
            chk("rst_cnt.retire", if0.retire_count, 32'd0);
         end
      end

      @(negedge clk);
      #1;
      chk("cnt.stall", if0.stall_count, 32'd1);
      chk("cnt.flush", if0.flush_count, 32'd1);
      chk("cnt.retire", if0.retire_count, 32'd9);

      // interlock-only instance
      @(negedge clk);
      drive1(1'b1, 1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
      drive1(1'b0, 1'b1, 1, 8, 9, 1'b0);
      #1;
      chk("ilk.add_x1", 32'(if1.stall), 32'd0);
      @(negedge clk);
      drive1(1'b0, 1'b1, 2, 1, 1, 1'b0);
      #1;
      chk("ilk.dep_ex", 32'(if1.stall), 32'd1);
      chk("ilk.fwd", 32'({if1.fwd_a, if1.fwd_b}), 32'd0);
      @(negedge clk);
      #1;
      chk("ilk.dep_mem", 32'(if1.stall), 32'd1);
      @(negedge clk);
      #1;
      chk("ilk.dep_wb", 32'(if1.stall), 32'd0);
      chk("ilk.cnt2", 32'(if1.stall_count), 32'd2);
      @(negedge clk);
      drive1(1'b0, 1'b1, 31, 8, 8, 1'b0);
      #1;
      chk("ilk.wr_xzr", 32'(if1.stall), 32'd0);
      @(negedge clk);
      drive1(1'b0, 1'b1, 3, 31, 31, 1'b0);
      #1;
      chk("ilk.rd_xzr", 32'(if1.stall), 32'd0);
      @(negedge clk);
      drive1(1'b0, 1'b1, 4, 3, 3, 1'b0);
      #1;
      chk("ilk.dep2_ex", 32'(if1.stall), 32'd1);
      @(negedge clk);
      #1;
      chk("ilk.dep2_mem", 32'(if1.stall), 32'd1);
      chk("ilk.cnt3", 32'(if1.stall_count), 32'd3);
      @(negedge clk);
      #1;
      chk("ilk.cnt_sat", 32'(if1.stall_count), 32'd3);
      @(negedge clk);
      drive1(1'b0, 1'b1, 5, 4, 4, 1'b0);
      #1;
      chk("ilk.dep3_ex", 32'(if1.stall), 32'd1);
      @(negedge clk);
      drive1(1'b1, 1'b1, 5, 4, 4, 1'b1);
      #1;
      chk("ilk.rst_stall", 32'(if1.stall), 32'd0);
      chk("ilk.rst_flush", 32'(if1.flush_ifid | if1.flush_idex |
                                 if1.flush_exmem), 32'd0);
      @(negedge clk);
      drive1(1'b0, 1'b1, 5, 4, 4, 1'b0);
      #1;
      chk("ilk.post_rst", 32'(if1.stall), 32'd0);
      chk("ilk.post_cnt", 32'({if1.stall_count, if1.flush_count,
                               if1.retire_count}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
